// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - instruction fetch into the IF/ID register with stall, flush, end and fault handling
module if_id_fetch_stage #(
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  localparam int         AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   pc_in,
  input  logic          if_id_write,
  input  logic          flush,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_instr,
  output logic          if_id_valid,
  output logic          done,
  output logic          fetch_err,
  output logic [15:0]   fetch_count
);

  localparam logic [31:0] BYTE_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] LAST_PC    = BYTE_LIMIT - 32'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [IMEM_WORDS];
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          fault;

  logic [31:0]   pc_nxt, instr_nxt;
  logic          valid_nxt, err_nxt;
  logic [15:0]   count_nxt;

  assign rd_idx  = pc_in[2 +: AW];
  // A same-cycle write to the word being fetched is forwarded to the pipeline.
  assign rd_word = (imem_we && (imem_waddr == rd_idx)) ? imem_wdata : mem[rd_idx];
  assign fault   = (pc_in[1:0] != 2'b00) || (pc_in >= BYTE_LIMIT);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state       <= state_nxt;
      if_id_pc    <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_valid <= valid_nxt;
      fetch_err   <= err_nxt;
      fetch_count <= count_nxt;
    end
  end

  // Defaults describe a bubble; only RUN overrides them.
  always_comb begin
    state_nxt = state;
    pc_nxt    = 32'd0;
    instr_nxt = NOP_INSTR;
    valid_nxt = 1'b0;
    err_nxt   = fetch_err;
    count_nxt = fetch_count;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (fault) begin
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end else if (!flush) begin
          if (!if_id_write) begin
            pc_nxt    = if_id_pc;
            instr_nxt = if_id_instr;
            valid_nxt = if_id_valid;
          end else begin
            pc_nxt    = pc_in;
            instr_nxt = rd_word;
            valid_nxt = 1'b1;
            count_nxt = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;
            if (pc_in == LAST_PC) state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_RUN;
          err_nxt   = 1'b0;
          count_nxt = 16'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - directed and randomized checks of if_id_fetch_stage against a reference model
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        if_id_write = 1'b1;
  logic        flush = 1'b0;
  logic        imem_we = 1'b0;
  logic [6:0]  imem_waddr = 7'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid, done, fetch_err;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = waiting for start, 1 = fetching, 2 = program ended.
  int          m_mode;
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_err;
  int          m_cnt;
  logic [31:0] mm [128];

  if_id_fetch_stage dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .if_id_write(if_id_write), .flush(flush),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .done(done), .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    if_id_pc, m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
    chk({tag, ".done"},  32'(done), 32'(m_mode == 2));
    chk({tag, ".err"},   32'(fetch_err), 32'(m_err));
    chk({tag, ".count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_instr = NOP; m_valid = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic bubble();
    m_pc = 0; m_instr = NOP; m_valid = 0;
  endtask

  task automatic step(input string tag, input logic [31:0] pc, input logic wr, input logic fl,
                      input logic st, input logic we, input logic [6:0] wa, input logic [31:0] wd);
    logic [31:0] word;
    start = st; pc_in = pc; if_id_write = wr; flush = fl;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    word = (we && wa == pc[8:2]) ? wd : mm[pc[8:2]];
    case (m_mode)
      0: begin bubble(); if (st) m_mode = 1; end
      1: begin
        if (pc % 4 != 0 || pc >= 32'd512) begin bubble(); m_err = 1; m_mode = 2; end
        else if (fl) bubble();
        else if (wr) begin
          m_pc = pc; m_instr = word; m_valid = 1;
          if (m_cnt < 65535) m_cnt++;
          if (pc == 32'd508) m_mode = 2;
        end
      end
      default: begin bubble(); if (st) begin m_mode = 1; m_err = 0; m_cnt = 0; end end
    endcase
    if (we) mm[wa] = wd;
    @(posedge clk);
    #1;
    start = 0; imem_we = 0;
    check_all(tag);
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc);
    step(tag, pc, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
  endtask

  task automatic go(input string tag);
    step(tag, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] pc, wd;
    logic [6:0]  wa;
    logic        wr, fl, st, we;
    int          r;

    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    // Load program: fixed head and tail words, random body.
    for (int i = 0; i < 128; i++) begin
      case (i)
        0: wd = 32'h00A00093;
        1: wd = 32'h00108113;
        2: wd = 32'h002081B3;
        3: wd = 32'h00000013;
        127: wd = 32'hCAFE0127;
        default: wd = $urandom;
      endcase
      step("load", 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 7'(i), wd);
    end

    go("start");
    fetch("f0", 32'd0);
    chk("f0.lit", if_id_instr, 32'h00A00093);
    fetch("f4", 32'd4);
    chk("f4.lit", if_id_instr, 32'h00108113);
    fetch("f8", 32'd8);
    fetch("f12", 32'd12);
    chk("count4.lit", 32'(fetch_count), 32'd4);
    chk("valid.lit", 32'(if_id_valid), 32'd1);

    fetch("pre_stall", 32'd4);
    for (int i = 0; i < 3; i++) begin
      step("stall", 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
      chk("stall.pc.lit", if_id_pc, 32'd4);
    end
    fetch("after_stall", 32'd8);
    chk("after_stall.lit", if_id_instr, 32'h002081B3);

    step("flush_stall", 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 32'd0);
    chk("flush.instr.lit", if_id_instr, NOP);

    step("bypass", 32'h14, 1'b1, 1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
    chk("bypass.lit", if_id_instr, 32'hDEADBEEF);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    fetch("idle_after_rst", 32'd0);

    go("restart");
    step("last_flush", 32'h1FC, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 32'd0);
    chk("last_flush.done.lit", 32'(done), 32'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       pc = ($urandom_range(0, 127) << 2) | 32'($urandom_range(1, 3));
      else if (r < 9)  pc = 32'h200 + ($urandom_range(0, 255) << 2);
      else if (r < 12) pc = 32'h1FC;
      else             pc = $urandom_range(0, 127) << 2;
      wr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      st = (m_mode == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 5) == 0);
      wa = ($urandom_range(0, 1) == 0) ? pc[8:2] : 7'($urandom_range(0, 127));
      step("rand", pc, wr, fl, st, we, wa, $urandom);
    end

    if (m_mode != 1) go("to_run");
    fetch("near_end", 32'h1F8);
    fetch("end", 32'h1FC);
    chk("end.done.lit", 32'(done), 32'd1);
    chk("end.pc.lit", if_id_pc, 32'h1FC);
    fetch("post_end1", 32'd0);
    chk("post_end.valid.lit", 32'(if_id_valid), 32'd0);
    fetch("post_end2", 32'd4);
    go("restart_done");
    chk("restart.count.lit", 32'(fetch_count), 32'd0);
    chk("restart.done.lit", 32'(done), 32'd0);

    fetch("misaligned", 32'h06);
    chk("misaligned.err.lit", 32'(fetch_err), 32'd1);
    go("restart_err");
    chk("restart.err.lit", 32'(fetch_err), 32'd0);
    fetch("range", 32'h200);
    chk("range.err.lit", 32'(fetch_err), 32'd1);
    fetch("range_after", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
# if_id_fetch_stage

Instruction-fetch consumer of the PC generator: takes the current `pc_in`, reads the instruction memory, and registers the PC/instruction pair into the IF/ID pipeline register with stall, flush, end-of-program and fault handling. It sits between the PC adder and the decode stage. The PC adder drives `pc_in`; the hazard unit drives `if_id_write`; the branch logic drives `flush`. It also owns the instruction memory load port used by the testbench/loader.

## Interface
- `IMEM_WORDS`, default 128: instruction memory depth in 32-bit words; byte limit = IMEM_WORDS*4 (0x200).
- `NOP_INSTR`, default 32'h00000013: bubble encoding (addi x0,x0,0).
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  single-cycle pulse; begins or restarts fetching.
- `pc_in`  in  32  byte address from the PC adder.
- `if_id_write`  in  1  1 = IF/ID may load; 0 = stall (hold).
- `flush`  in  1  1 = replace next IF/ID content with a bubble.
- `imem_we`  in  1  instruction memory write enable.
- `imem_waddr`  in  log2(IMEM_WORDS)  word address for the write.
- `imem_wdata`  in  32  write data.
- `if_id_pc`  out  32  registered PC of the held instruction.
- `if_id_instr`  out  32  registered instruction.
- `if_id_valid`  out  1  1 = IF/ID holds a real instruction.
- `done`  out  1  program end reached; pipeline is being fed bubbles.
- `fetch_err`  out  1  sticky; misaligned or out-of-range `pc_in` seen.
- `fetch_count`  out  16  number of valid instructions latched, saturating at 16'hFFFF.

## Operation
- Memory: IMEM_WORDS x 32 array, not reset. Synchronous write when `imem_we`=1, accepted in any state. Asynchronous read at index `pc_in[2+:log2(IMEM_WORDS)]`. Write-to-read bypass: if `imem_we` is set and `imem_waddr` equals the read index in the same cycle, the latched instruction is `imem_wdata`.
- FSM states:
  - IDLE: IF/ID loads a bubble every cycle. `start` -> RUN.
  - RUN: per-cycle priority order:
    - fault: `pc_in[1:0]`!=0 or `pc_in` >= IMEM_WORDS*4 -> bubble, set `fetch_err`, go to DONE.
    - `flush`=1 -> bubble (pc=0, instr=NOP_INSTR, valid=0).
    - `if_id_write`=0 -> hold all IF/ID outputs unchanged.
    - otherwise -> latch `pc_in`, memory word, valid=1, and increment `fetch_count`. If `pc_in` == IMEM_WORDS*4-4, go to DONE after latching.
  - DONE: `done`=1. IF/ID loads bubbles regardless of `if_id_write`/`flush`. `start` -> RUN and clears `done`, `fetch_err` and `fetch_count`.
- `start` while in RUN is ignored.
- Flush has priority over stall. A flush during a stall still inserts the bubble.
- A flush in the same cycle as the last-address fetch: bubble, no count, and the FSM stays in RUN.
- `fetch_count` does not wrap.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - state IDLE
  - `if_id_pc`=0, `if_id_instr`=NOP_INSTR, `if_id_valid`=0
  - `done`=0, `fetch_err`=0, `fetch_count`=0
  - memory contents unaffected
- Reset mid-RUN aborts immediately. Release requires a new `start`.
- Latency: the `pc_in` presented in cycle N appears on `if_id_*` after edge N+1 (one register stage). There is no combinational path from inputs to outputs.
- `start` at edge N -> RUN; the first fetch is latched at edge N+1.
- `done` rises on the same edge that latches the last instruction. Bubbles follow from the next edge.
- `fetch_err` rises on the edge that latches the bubble for the faulting PC.
- A stall holds the outputs for exactly as many cycles as `if_id_write`=0.

## Test plan
- Load words 0..3 = 0x00A00093, 0x00108113, 0x002081B3, 0x00000013; reset, start, pc 0,4,8,12 on successive cycles -> `if_id_instr` follows one cycle later, valid=1, `fetch_count`=4.
- Stall: `if_id_write`=0 for 3 cycles while `pc_in`=8 -> outputs hold pc 4 / 0x00108113 for 3 cycles, count unchanged. Then pc 8 latches.
- Flush and stall together at pc 0x10 -> pc=0, instr=0x00000013, valid=0, no count.
- Sequence to pc 0x1FC -> word 127 latched, `done`=1 on the same edge, then valid=0 bubbles. `start` -> `done`=0, `fetch_count`=0.
- pc 0x06, and separately pc 0x200 -> bubble, `fetch_err`=1, DONE.
- Write word 5 = 0xDEADBEEF while `pc_in`=0x14 -> `if_id_instr`=0xDEADBEEF. Assert `rst`=0 mid-run -> all outputs return to their reset values without waiting for a clock edge.
